hawk_axi_wr_downsizer: RTL and testbench
========================================

# hawk_axi_wr_downsizer

Write-path 2:1 width converter between the HAWK/CPU write crossbar and the 256-bit DDR memory-controller write port. Each 512-bit cacheline beat from the crossbar becomes two 256-bit beats, low half first. One burst in becomes exactly one burst out. The B response is forwarded back with the original ID. One transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 64, AXI address width
- ID_WIDTH, 6, AXI ID width
- USER_WIDTH, 1, aw/w/b user width
- S_DATA_WIDTH, 512, slave data width; fixed at 2×M_DATA_WIDTH
- M_DATA_WIDTH, 256, master data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion/awuser  in  per AXI4  slave write address
- s_axi_awvalid  in  1, s_axi_awready  out  1  slave AW handshake
- s_axi_wdata  in  512, s_axi_wstrb  in  64, s_axi_wlast  in  1, s_axi_wuser  in  USER_WIDTH  slave write data
- s_axi_wvalid  in  1, s_axi_wready  out  1  slave W handshake
- s_axi_bid  out  ID_WIDTH, s_axi_bresp  out  2, s_axi_buser  out  USER_WIDTH, s_axi_bvalid  out  1, s_axi_bready  in  1  slave response
- m_axi_aw* (same field set)  out  per AXI4, m_axi_awvalid  out  1, m_axi_awready  in  1  master write address
- m_axi_wdata  out  256, m_axi_wstrb  out  32, m_axi_wlast  out  1, m_axi_wuser  out  USER_WIDTH, m_axi_wvalid  out  1, m_axi_wready  in  1  master write data
- m_axi_bid  in  ID_WIDTH, m_axi_bresp  in  2, m_axi_buser  in  USER_WIDTH, m_axi_bvalid  in  1, m_axi_bready  out  1  master response
- prot_err  out  1  one-cycle pulse on a detected protocol violation

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - s_axi_awready=1.
  - On AW handshake, latch all AW fields and go to ADDR.
- **ADDR**
  - m_axi_awvalid=1.
  - m_axi_awaddr, id, burst, lock, cache, prot, qos, region and user are the latched values.
  - m_axi_awsize=5.
  - m_axi_awlen={awlen[6:0],1'b1}, so master beats = 2×(awlen+1).
  - On m_axi_awready, go to DATA.
- **W buffer**
  - Holds one 512-bit data beat, 64-bit strobe, a computed last flag and user.
  - A half pointer `half` selects the output half.
  - Fill condition: state is ADDR or DATA, and either the buffer is empty, or it is full with half=1 and m_axi_wready=1 (refill in the same cycle).
  - s_axi_wready equals the fill condition.
  - On capture: half<=0, and the slave beat counter increments.
- **DATA**
  - m_axi_wvalid = buffer full.
  - half=0 drives data[255:0] and strb[31:0]; half=1 drives data[511:256] and strb[63:32].
  - m_axi_wlast = half & computed last.
  - Computed last = (beat count == latched awlen[6:0]). s_axi_wlast is not used for control.
  - On m_axi_wready: half=0 goes to half=1. half=1 empties the buffer unless it refills that cycle.
  - Accepting the master beat with wlast=1 goes to RESP.
- **RESP**
  - s_axi_bvalid = m_axi_bvalid and m_axi_bready = s_axi_bready (combinational pass-through).
  - s_axi_bid = latched awid. bresp and buser pass through.
  - On handshake, go to IDLE.
- **prot_err** pulses for one cycle when any of these is detected:
  - awlen[7]=1 at AW capture; the transfer proceeds with awlen[6:0].
  - awsize≠6 at AW capture.
  - s_axi_wlast ≠ computed last at W capture.
- **Reset outputs:** all valids 0, s_axi_awready 0 during reset, state IDLE, buffer empty, counter 0, prot_err 0, data/addr outputs 0.
- **Reset mid-transaction:** the transaction is abandoned with no B issued. The MC side is reset with the same rst.

## Timing
- Best case, single beat (awlen=0), all ready signals high:
  - cycle 0: s AW handshake.
  - cycle 1: m_axi_awvalid, W captured.
  - cycle 2: low half.
  - cycle 3: high half with wlast.
  - cycle 4: RESP.
- Sustained throughput is one 256-bit master beat per cycle, so the slave side accepts one beat every 2 cycles.
- W may be accepted while AW is still pending downstream, but no m_axi_wvalid is driven before the master AW handshake.
- All m_axi_* outputs except bready come from registers. s_axi_wready, s_axi_bvalid and m_axi_bready are combinational.
- Valid is never dropped without a handshake. Data is held stable while valid=1 and ready=0.

## Structure
- In hacd_pkg:
  - `HAWK_DS_RATIO=2`
  - `HAWK_S_AWSIZE=6`, `HAWK_M_AWSIZE=5`
  - typedef `hawk_ds_aw_t`, a packed struct of the latched AW fields
  - typedef `hawk_ds_state_e`
- One sub-module: `hawk_wr_beat_splitter`, which owns the buffer, half pointer, beat counter and last generation. The FSM and B path stay in the top.

## Test plan
- awlen=0, addr 0x8000_0040, wdata = {256'hB…B, 256'hA…A}, all strb=1 → m_axi_awlen=1, awsize=5; beat0=A…A strb 32'hFFFF_FFFF wlast=0; beat1=B…B wlast=1; B with bid=awid=5, OKAY.
- awlen=3 with m_axi_wready toggling 1/0 → 8 master beats in order, wlast only on the 8th, no data lost or duplicated, 1 B.
- m_axi_awready held low for 10 cycles with s_axi_wvalid high → exactly one slave beat captured, s_axi_wready=0 afterwards, m_axi_wvalid=0 until the AW handshake.
- awlen=1 with s_axi_wlast asserted on the first beat → prot_err pulses once, still 4 master beats, wlast on the 4th.
- m_axi_bresp=SLVERR and s_axi_bready stalled 3 cycles → bvalid held, bresp=2 forwarded, next s AW accepted only after the handshake.
- rst asserted in DATA after 1 master beat → next cycle all valids 0; a fresh awlen=0 write completes normally.

Source files
------------

// File: rtl/hacd_pkg.sv
// hacd_pkg: shared types and constants for the HAWK 512->256 write downsizer.
package hacd_pkg;
  localparam int HAWK_DS_RATIO = 2;
  localparam logic [2:0] HAWK_S_AWSIZE = 3'd6;
  localparam logic [2:0] HAWK_M_AWSIZE = 3'd5;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} hawk_ds_state_e;
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } hawk_ds_aw_t;
endpackage

// File: rtl/hawk_wr_beat_splitter.sv
// hawk_wr_beat_splitter: one-beat W buffer emitting each wide beat as two narrow halves, low first.
module hawk_wr_beat_splitter
  import hacd_pkg::*;
#(
  parameter int MW = 256,
  parameter int UW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          fill_ok,
  input  logic                          send_d,
  input  logic [6:0]                    len,
  input  logic [HAWK_DS_RATIO*MW-1:0]   s_wdata,
  input  logic [HAWK_DS_RATIO*MW/8-1:0] s_wstrb,
  input  logic                          s_wlast,
  input  logic [UW-1:0]                 s_wuser,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [MW-1:0]                 m_wdata,
  output logic [MW/8-1:0]               m_wstrb,
  output logic                          m_wlast,
  output logic [UW-1:0]                 m_wuser,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic                          last_err
);
  localparam int SW = HAWK_DS_RATIO * MW;
  logic full, half, done, buf_last, m_hs, s_hs, cur_last, full_d, half_d, last_d;
  logic [6:0] cnt;
  logic [SW-1:0] buf_data, data_d;
  logic [SW/8-1:0] buf_strb, strb_d;
  logic [UW-1:0] buf_user, user_d;
  // done blocks early capture of the next burst's W while this one drains
  always_comb begin
    m_hs = m_wvalid & m_wready;
    s_wready = fill_ok & ~done & (~full | (half & m_hs));
    s_hs = s_wready & s_wvalid;
    cur_last = cnt == len;
    last_err = s_hs & (s_wlast != cur_last);
    full_d = s_hs | (full & ~(half & m_hs));
    half_d = s_hs ? 1'b0 : (half | m_hs);
    data_d = s_hs ? s_wdata : buf_data;
    strb_d = s_hs ? s_wstrb : buf_strb;
    user_d = s_hs ? s_wuser : buf_user;
    last_d = s_hs ? cur_last : buf_last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      half <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      buf_data <= '0;
      buf_strb <= '0;
      buf_user <= '0;
      buf_last <= 1'b0;
      m_wvalid <= 1'b0;
      m_wdata <= '0;
      m_wstrb <= '0;
      m_wlast <= 1'b0;
      m_wuser <= '0;
    end else begin
      full <= full_d;
      half <= half_d;
      done <= start ? 1'b0 : (done | (s_hs & cur_last));
      cnt <= start ? 7'd0 : cnt + 7'(s_hs);
      buf_data <= data_d;
      buf_strb <= strb_d;
      buf_user <= user_d;
      buf_last <= last_d;
      m_wvalid <= full_d & send_d;
      m_wdata <= half_d ? data_d[SW-1:MW] : data_d[MW-1:0];
      m_wstrb <= half_d ? strb_d[SW/8-1:MW/8] : strb_d[MW/8-1:0];
      m_wlast <= half_d & last_d;
      m_wuser <= user_d;
    end
  end
endmodule

// File: rtl/hawk_axi_wr_downsizer.sv
// hawk_axi_wr_downsizer: AXI4 write-path 2:1 width converter, one transaction outstanding.
module hawk_axi_wr_downsizer
  import hacd_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 6,
  parameter int USER_WIDTH   = 1,
  parameter int S_DATA_WIDTH = 512,
  parameter int M_DATA_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awqos,
  input  logic [3:0]                s_axi_awregion,
  input  logic [USER_WIDTH-1:0]     s_axi_awuser,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [S_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic [USER_WIDTH-1:0]     s_axi_wuser,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic [USER_WIDTH-1:0]     s_axi_buser,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic [USER_WIDTH-1:0]     m_axi_awuser,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [M_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic [USER_WIDTH-1:0]     m_axi_wuser,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic [USER_WIDTH-1:0]     m_axi_buser,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      prot_err
);
  hawk_ds_state_e state, state_d;
  hawk_ds_aw_t aw;
  logic aw_hs, w_err, unused_bid;
  assign unused_bid = ^m_axi_bid;
  always_comb begin
    s_axi_awready = (state == IDLE) & ~rst;
    aw_hs = s_axi_awready & s_axi_awvalid;
    s_axi_bvalid = (state == RESP) & m_axi_bvalid;
    m_axi_bready = (state == RESP) & s_axi_bready;
    s_axi_bid = m_axi_awid;
    s_axi_bresp = m_axi_bresp;
    s_axi_buser = m_axi_buser;
    {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
     m_axi_awqos, m_axi_awregion} = aw;
    state_d = state;
    case (state)
      IDLE: state_d = aw_hs ? ADDR : IDLE;
      ADDR: state_d = (m_axi_awvalid & m_axi_awready) ? DATA : ADDR;
      DATA: state_d = (m_axi_wvalid & m_axi_wready & m_axi_wlast) ? RESP : DATA;
      RESP: state_d = (m_axi_bvalid & m_axi_bready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // awlen[7] is dropped: the doubled master burst must still fit in 8 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      aw <= '0;
      m_axi_awid <= '0;
      m_axi_awaddr <= '0;
      m_axi_awuser <= '0;
      m_axi_awvalid <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      state <= state_d;
      m_axi_awvalid <= aw_hs | (m_axi_awvalid & ~m_axi_awready);
      prot_err <= w_err | (aw_hs & (s_axi_awlen[7] | (s_axi_awsize != HAWK_S_AWSIZE)));
      if (aw_hs) begin
        aw <= '{len: {s_axi_awlen[6:0], 1'b1}, size: HAWK_M_AWSIZE, burst: s_axi_awburst,
                lock: s_axi_awlock, cache: s_axi_awcache, prot: s_axi_awprot,
                qos: s_axi_awqos, region: s_axi_awregion};
        m_axi_awid <= s_axi_awid;
        m_axi_awaddr <= s_axi_awaddr;
        m_axi_awuser <= s_axi_awuser;
      end
    end
  end
  hawk_wr_beat_splitter #(.MW(M_DATA_WIDTH), .UW(USER_WIDTH)) u_split (
    .clk      (clk),
    .rst      (rst),
    .start    (aw_hs),
    .fill_ok  ((state == ADDR) || (state == DATA)),
    .send_d   (state_d == DATA),
    .len      (aw.len[7:1]),
    .s_wdata  (s_axi_wdata),
    .s_wstrb  (s_axi_wstrb),
    .s_wlast  (s_axi_wlast),
    .s_wuser  (s_axi_wuser),
    .s_wvalid (s_axi_wvalid),
    .s_wready (s_axi_wready),
    .m_wdata  (m_axi_wdata),
    .m_wstrb  (m_axi_wstrb),
    .m_wlast  (m_axi_wlast),
    .m_wuser  (m_axi_wuser),
    .m_wvalid (m_axi_wvalid),
    .m_wready (m_axi_wready),
    .last_err (w_err)
  );
endmodule

// File: tb/tb_hawk_axi_wr_downsizer.sv
// tb_hawk_axi_wr_downsizer: scoreboard bench for the 512->256 AXI write downsizer.
module tb_hawk_axi_wr_downsizer;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [5:0] s_axi_awid, s_axi_bid, m_axi_awid, m_axi_bid;
  logic [63:0] s_axi_awaddr, m_axi_awaddr;
  logic [7:0] s_axi_awlen, m_axi_awlen;
  logic [2:0] s_axi_awsize, m_axi_awsize, s_axi_awprot, m_axi_awprot;
  logic [1:0] s_axi_awburst, m_axi_awburst, s_axi_bresp, m_axi_bresp;
  logic s_axi_awlock, m_axi_awlock;
  logic [3:0] s_axi_awcache, m_axi_awcache, s_axi_awqos, m_axi_awqos, s_axi_awregion, m_axi_awregion;
  logic s_axi_awuser, m_axi_awuser, s_axi_wuser, m_axi_wuser, s_axi_buser, m_axi_buser;
  logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic [511:0] s_axi_wdata;
  logic [63:0] s_axi_wstrb;
  logic [255:0] m_axi_wdata;
  logic [31:0] m_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready, prot_err;

  hawk_axi_wr_downsizer dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .prot_err(prot_err)
  );

  typedef struct packed {logic [511:0] d; logic [63:0] s; logic l;} sbeat_t;
  typedef struct packed {logic [255:0] d; logic [31:0] s; logic l;} mbeat_t;
  typedef struct packed {logic [63:0] a; logic [7:0] l; logic [5:0] id;} awx_t;
  typedef struct packed {logic [5:0] id; logic [1:0] r;} bx_t;
  sbeat_t sq[$];
  mbeat_t mq[$];
  awx_t awq[$];
  bx_t bq[$];
  int errors = 0, checks = 0;
  int prot_cnt, pre_cnt, mw_cnt, aw_stall_c, b_stall_c;
  logic aw_done, bdone, tog;
  logic [1:0] cur_resp;
  logic [5:0] cur_id;
  logic p_wv, p_wr, p_av, p_ar, p_bv, p_br;
  logic [289:0] p_wd;
  logic [64:0] p_ad;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  task automatic step();
    logic hsaw, hsw, mhaw, mhw, mwl, bh, mbh, sbv;
    awx_t ea;
    mbeat_t em;
    bx_t eb;
    sbeat_t sb;
    @(negedge clk);
    hsaw = s_axi_awvalid & s_axi_awready;
    hsw = s_axi_wvalid & s_axi_wready;
    mhaw = m_axi_awvalid & m_axi_awready;
    mhw = m_axi_wvalid & m_axi_wready;
    mwl = mhw & m_axi_wlast;
    bh = s_axi_bvalid & s_axi_bready;
    mbh = m_axi_bvalid & m_axi_bready;
    sbv = s_axi_bvalid;
    if (prot_err) prot_cnt++;
    if (p_wv && !p_wr) chk("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast}, p_wd);
    if (p_av && !p_ar) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, p_ad);
    if (p_bv && !p_br) chk("b_hold", s_axi_bvalid, 1'b1);
    if (s_axi_bvalid && !s_axi_bready) chk("aw_blocked", s_axi_awready, 1'b0);
    if (m_axi_wvalid && !aw_done) chk("w_early", m_axi_wvalid, 1'b0);
    if (hsw && !aw_done) pre_cnt++;
    if (mhaw) begin
      if (awq.size() == 0) chk("aw_unexp", mhaw, 1'b0);
      else begin
        ea = awq.pop_front();
        chk("aw", {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awid, m_axi_awburst, m_axi_awqos},
            {ea.a, ea.l, 3'd5, ea.id, 2'b01, ea.id[3:0]});
      end
      aw_done = 1'b1;
    end
    if (mhw) begin
      mw_cnt++;
      if (mq.size() == 0) chk("w_unexp", mhw, 1'b0);
      else begin
        em = mq.pop_front();
        chk("wbeat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, em);
      end
    end
    if (bh) begin
      if (bq.size() == 0) chk("b_unexp", bh, 1'b0);
      else begin
        eb = bq.pop_front();
        chk("b", {s_axi_bid, s_axi_bresp}, eb);
      end
      bdone = 1'b1;
    end
    p_wv = m_axi_wvalid; p_wr = m_axi_wready;
    p_wd = {m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast};
    p_av = m_axi_awvalid; p_ar = m_axi_awready; p_ad = {m_axi_awvalid, m_axi_awaddr};
    p_bv = s_axi_bvalid; p_br = s_axi_bready;
    @(posedge clk);
    #1;
    if (hsaw) s_axi_awvalid = 1'b0;
    if (hsw) sb = sq.pop_front();
    s_axi_wvalid = sq.size() > 0;
    if (sq.size() > 0) {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = sq[0];
    m_axi_awready = aw_stall_c == 0;
    if (aw_stall_c > 0) aw_stall_c--;
    m_axi_wready = tog ? !m_axi_wready : 1'b1;
    if (mbh) m_axi_bvalid = 1'b0;
    if (mwl) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp = cur_resp;
      m_axi_bid = cur_id ^ 6'h3F;
    end
    if (sbv && b_stall_c > 0) b_stall_c--;
    s_axi_bready = b_stall_c == 0;
  endtask

  task automatic wr(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic bad_last, input logic [1:0] resp,
                    input int aw_stall, input int b_stall, input logic toggle,
                    input int abort_at, input int exp_prot, input logic fixed);
    int nb;
    logic [511:0] d;
    logic [63:0] s;
    prot_cnt = 0; pre_cnt = 0; mw_cnt = 0; aw_done = 1'b0; bdone = 1'b0;
    cur_id = id; cur_resp = resp; tog = toggle;
    aw_stall_c = aw_stall; b_stall_c = b_stall;
    m_axi_awready = aw_stall == 0; s_axi_bready = b_stall == 0; m_axi_wready = 1'b1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
    s_axi_awburst = 2'b01; s_axi_awqos = id[3:0]; s_axi_awvalid = 1'b1;
    awq.push_back('{a: addr, l: {len[6:0], 1'b1}, id: id});
    nb = int'(len[6:0]) + 1;
    for (int i = 0; i < nb; i++) begin
      d = fixed ? {{64{4'hB}}, {64{4'hA}}} : rnd512();
      s = fixed ? '1 : {$urandom, $urandom};
      sq.push_back('{d: d, s: s, l: (i == nb - 1) || (bad_last && i == 0)});
      mq.push_back('{d: d[255:0], s: s[31:0], l: 1'b0});
      mq.push_back('{d: d[511:256], s: s[63:32], l: i == nb - 1});
    end
    if (abort_at == 0) bq.push_back('{id: id, r: resp});
    s_axi_wvalid = 1'b1;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = sq[0];
    for (int c = 0; c < 300 && !bdone; c++) begin
      step();
      if (abort_at != 0 && mw_cnt >= abort_at) break;
    end
    if (abort_at != 0) begin
      chk("abort_reach", mw_cnt, abort_at);
      rst = 1'b1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b0;
      sq.delete(); mq.delete(); awq.delete();
      @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {s_axi_awready, s_axi_wready, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid}, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      {p_wv, p_av, p_bv} = '0;
    end else begin
      chk("done", bdone, 1'b1);
      chk("prot_cnt", prot_cnt, exp_prot);
      chk("w_left", mq.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock} = '0;
    {s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser, s_axi_awvalid} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid, s_axi_bready} = '0;
    {m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
    {p_wv, p_wr, p_av, p_ar, p_bv, p_br, p_wd, p_ad} = '0;
    {prot_cnt, pre_cnt, mw_cnt, aw_stall_c, b_stall_c} = '0;
    {aw_done, bdone, tog, cur_resp, cur_id} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {s_axi_awready, s_axi_wready, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, prot_err}, '0);
    chk("rst_addr", {m_axi_awaddr, m_axi_awlen, m_axi_wdata}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", s_axi_awready, 1'b1);
    @(posedge clk);
    #1;
    wr(6'd5, 64'h8000_0040, 8'd0, 3'd6, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1'b1);
    wr(6'd7, 64'h8000_1000, 8'd3, 3'd6, 1'b0, 2'd0, 0, 0, 1'b1, 0, 0, 1'b0);
    wr(6'd9, 64'h8000_2000, 8'd1, 3'd6, 1'b0, 2'd0, 10, 0, 1'b0, 0, 0, 1'b0);
    chk("pre_aw_capture", pre_cnt, 1);
    wr(6'd3, 64'h8000_3000, 8'd1, 3'd6, 1'b1, 2'd0, 0, 0, 1'b0, 0, 1, 1'b0);
    wr(6'd2, 64'h8000_4000, 8'd0, 3'd6, 1'b0, 2'd2, 0, 3, 1'b0, 0, 0, 1'b0);
    wr(6'd4, 64'h8000_5000, 8'h80, 3'd5, 1'b0, 2'd0, 0, 0, 1'b0, 0, 1, 1'b0);
    wr(6'd12, 64'h8000_6000, 8'd15, 3'd6, 1'b0, 2'd0, 2, 1, 1'b1, 0, 0, 1'b0);
    wr(6'd1, 64'h8000_7000, 8'd1, 3'd6, 1'b0, 2'd0, 0, 0, 1'b0, 1, 0, 1'b0);
    wr(6'd6, 64'h8000_8000, 8'd0, 3'd6, 1'b0, 2'd0, 0, 0, 1'b0, 0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
